spad_hist_acc: RTL and testbench

Multi-channel SPAD time-of-arrival histogram accumulator. It replaces the fixed single-channel SPAD data source. Per-channel TDC bin indices are binned into saturating counters while a measurement runs. When a programmed event count is reached, the block raises an interrupt to the CPU, and the CPU reads the bins over the Wishbone data bus.

---
 rtl/spad_hist_acc.sv | 223 ++++++++++++++++++++++
 tb/tb_spad_hist_acc.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spad_hist_acc.sv
// spad_hist_acc - multi-channel SPAD time-of-arrival histogram accumulator.
//
// Each channel delivers a TDC bin index with a one-cycle event strobe. While a
// measurement runs, every accepted event increments a saturating counter for
// that (channel, bin) pair. When the programmed event target is reached the
// block raises a level interrupt. The CPU then reads the bins over Wishbone.
//
// Ports
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_ev_valid[NCH]       per-channel event strobe
//   i_ev_bin              per-channel bin index, channel c in slice c
//   i_wb_adr/dat/we/cyc   Wishbone request (byte address, bits [1:0] ignored)
//   o_wb_rdt, o_wb_ack    read data (zero outside ack), single-cycle ack
//   o_irq                 measurement-done interrupt (level)
//   o_busy                high while clearing or running
//
// CNTW must be at least 2. NMW must be at most 32.
module spad_hist_acc #(
   parameter int NCH   = 2,
   parameter int NBINS = 64,
   parameter int CNTW  = 16,
   parameter int NMW   = 24
) (
   input  logic                            i_clk,
   input  logic                            i_rst,
   input  logic [NCH-1:0]                  i_ev_valid,
   input  logic [NCH*$clog2(NBINS)-1:0]    i_ev_bin,
   input  logic [11:0]                     i_wb_adr,
   input  logic [31:0]                     i_wb_dat,
   input  logic                            i_wb_we,
   input  logic                            i_wb_cyc,
   output logic [31:0]                     o_wb_rdt,
   output logic                            o_wb_ack,
   output logic                            o_irq,
   output logic                            o_busy
);
   localparam int BW   = $clog2(NBINS);
   localparam int NTOT = NCH * NBINS;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_CLEAR = 2'd1;
   localparam logic [1:0] ST_RUN   = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   logic [1:0]     state_reg;
   logic [NMW-1:0] target_reg;
   logic [NMW-1:0] evcnt_reg;
   logic           done_reg;
   logic           sat_reg;
   logic           cont_reg;
   logic           start_after_clear_reg;
   logic [BW-1:0]  clr_idx_reg;

   // Bus decode. An access is taken when cyc is high and no ack is showing,
   // which also enforces the idle cycle between consecutive acks.
   logic [9:0] wadr;
   logic [9:0] bofs;
   logic       wb_go;
   logic       ctrl_wr;
   logic       abort_wr;
   logic       tgt_wr;
   logic       stat_rd;
   logic       in_bins;
   int         rd_ch;

   assign wadr     = i_wb_adr[11:2];
   assign bofs     = wadr - 10'd256;
   assign wb_go    = i_wb_cyc && !o_wb_ack;
   assign ctrl_wr  = wb_go && i_wb_we && (wadr == 10'd0);
   assign abort_wr = ctrl_wr && i_wb_dat[3];
   assign tgt_wr   = wb_go && i_wb_we && (wadr == 10'd1);
   assign stat_rd  = wb_go && !i_wb_we && (wadr == 10'd2);
   assign in_bins  = (wadr >= 10'd256) && (int'(bofs) < NTOT);
   assign rd_ch    = int'(bofs) >> BW;
   assign o_busy   = (state_reg == ST_CLEAR) || (state_reg == ST_RUN);

   logic unused_bits;
   assign unused_bits = ^{i_wb_adr[1:0], i_wb_dat};

   logic [NCH-1:0]           acc;
   logic [NCH-1:0]           sat_ch;
   logic [NCH-1:0][CNTW-1:0] bin_rdata;
   logic [NMW:0]             run_cnt;
   logic                     hit;
   logic                     sat_hit;
   logic [31:0]              rd_data;

   // Channels are admitted in ascending order until the running count meets
   // the target; a zero target admits everything and lets the count wrap.
   always_comb begin
      acc     = '0;
      run_cnt = {1'b0, evcnt_reg};
      for (int c = 0; c < NCH; c++) begin
         if (state_reg == ST_RUN && !abort_wr && i_ev_valid[c] &&
             (target_reg == '0 || run_cnt < {1'b0, target_reg})) begin
            acc[c]  = 1'b1;
            run_cnt = run_cnt + 1'b1;
         end
      end
      hit     = (target_reg != '0) && (run_cnt >= {1'b0, target_reg});
      sat_hit = |(acc & sat_ch);
   end

   // One counter array per channel with its own write port, so all channels
   // update in the same cycle. The increment reads the array asynchronously,
   // so a write is visible to the next cycle's event and back-to-back hits
   // on one bin are never lost.
   genvar gi;
   generate
      for (gi = 0; gi < NCH; gi++) begin : g_ch
         logic [CNTW-1:0] bin_mem [NBINS];
         logic [BW-1:0]   ev_idx;
         logic [CNTW-1:0] cur;

         assign ev_idx = i_ev_bin[gi*BW +: BW];
         assign cur    = bin_mem[ev_idx];
         // Counter is at max or one below: after this event it is saturated.
         assign sat_ch[gi]    = &cur[CNTW-1:1];
         assign bin_rdata[gi] = bin_mem[bofs[BW-1:0]];

         always_ff @(posedge i_clk) begin
            if (state_reg == ST_CLEAR) begin
               bin_mem[clr_idx_reg] <= '0;
            end else if (acc[gi] && !(&cur)) begin
               bin_mem[ev_idx] <= cur + 1'b1;
            end
         end
      end
   endgenerate

   always_comb begin
      rd_data = '0;
      if (wadr == 10'd1) begin
         rd_data[NMW-1:0] = target_reg;
      end else if (wadr == 10'd2) begin
         rd_data[2:0] = {sat_reg, done_reg, o_busy};
      end else if (wadr == 10'd3) begin
         rd_data[NMW-1:0] = evcnt_reg;
      end else if (in_bins) begin
         for (int c = 0; c < NCH; c++) begin
            if (rd_ch == c) rd_data[CNTW-1:0] = bin_rdata[c];
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_reg             <= ST_IDLE;
         target_reg            <= '0;
         evcnt_reg             <= '0;
         done_reg              <= 1'b0;
         sat_reg               <= 1'b0;
         cont_reg              <= 1'b0;
         start_after_clear_reg <= 1'b0;
         clr_idx_reg           <= '0;
         o_irq                 <= 1'b0;
         o_wb_ack              <= 1'b0;
         o_wb_rdt              <= '0;
      end else begin
         o_wb_ack <= wb_go;
         o_wb_rdt <= (wb_go && !i_wb_we) ? rd_data : 32'd0;

         if (tgt_wr) target_reg <= i_wb_dat[NMW-1:0];

         // Acknowledge: a STATUS read or any CTRL write drops done and irq.
         // A completion in this same cycle overrides below.
         if (stat_rd || ctrl_wr) begin
            done_reg <= 1'b0;
            o_irq    <= 1'b0;
         end

         case (state_reg)
            ST_CLEAR: begin
               if (abort_wr) begin
                  state_reg <= ST_IDLE;
               end else begin
                  clr_idx_reg <= clr_idx_reg + 1'b1;
                  if (clr_idx_reg == BW'(NBINS - 1)) begin
                     state_reg <= start_after_clear_reg ? ST_RUN : ST_IDLE;
                  end
               end
            end
            ST_RUN: begin
               if (abort_wr) begin
                  state_reg <= ST_IDLE;
               end else begin
                  evcnt_reg <= run_cnt[NMW-1:0];
                  if (sat_hit) sat_reg <= 1'b1;
                  if (hit) begin
                     state_reg <= ST_DONE;
                     done_reg  <= 1'b1;
                     o_irq     <= 1'b1;
                  end
               end
            end
            default: begin // ST_IDLE and ST_DONE
               if (state_reg == ST_DONE && cont_reg) begin
                  // Continuous mode: rearm immediately, irq left pending.
                  state_reg <= ST_RUN;
                  evcnt_reg <= '0;
               end else if (ctrl_wr) begin
                  cont_reg <= i_wb_dat[2];
                  if (i_wb_dat[1]) begin
                     state_reg             <= ST_CLEAR;
                     clr_idx_reg           <= '0;
                     start_after_clear_reg <= i_wb_dat[0];
                     evcnt_reg             <= '0;
                     sat_reg               <= 1'b0;
                  end else if (i_wb_dat[0]) begin
                     state_reg <= ST_RUN;
                     evcnt_reg <= '0;
                     sat_reg   <= 1'b0;
                  end else begin
                     state_reg <= ST_IDLE;
                  end
               end else if (state_reg == ST_DONE && stat_rd) begin
                  state_reg <= ST_IDLE;
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_spad_hist_acc.sv
// Testbench for spad_hist_acc: directed scenarios plus randomized events,
// with bus reads checked by a scoreboard monitor against a count-level model.
module tb_spad_hist_acc;
   localparam int NCH   = 2;
   localparam int NBINS = 64;
   localparam int CNTW  = 4;
   localparam int NMW   = 24;
   localparam int BW    = 6;
   localparam int BMAX  = (1 << CNTW) - 1;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic [NCH-1:0]       ev_valid = '0;
   logic [NCH*BW-1:0]    ev_bin = '0;
   logic [11:0]          wb_adr = '0;
   logic [31:0]          wb_dat = '0;
   logic                 wb_we = 1'b0;
   logic                 wb_cyc = 1'b0;
   logic [31:0]          wb_rdt;
   logic                 wb_ack;
   logic                 irq;
   logic                 busy;

   spad_hist_acc #(.NCH(NCH), .NBINS(NBINS), .CNTW(CNTW), .NMW(NMW)) dut (
      .i_clk(clk), .i_rst(rst), .i_ev_valid(ev_valid), .i_ev_bin(ev_bin),
      .i_wb_adr(wb_adr), .i_wb_dat(wb_dat), .i_wb_we(wb_we), .i_wb_cyc(wb_cyc),
      .o_wb_rdt(wb_rdt), .o_wb_ack(wb_ack), .o_irq(irq), .o_busy(busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   logic [31:0] exp_q[$];
   string       name_q[$];

   // Reference model: histogram contents and measurement bookkeeping.
   int m_bin[NCH][NBINS];
   int m_ev = 0;
   int m_target = 0;
   bit m_run = 0;
   bit m_done = 0;
   bit m_sat = 0;
   bit m_cont = 0;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endfunction

   function automatic logic [11:0] bin_addr(int c, int b);
      return 12'(32'h400 + 4 * (c * NBINS + b));
   endfunction

   // Monitor: every ack pops the oldest expected read value.
   logic        prev_ack = 1'b0;
   logic [31:0] mon_e;
   string       mon_n;
   always @(negedge clk) begin
      if (wb_ack) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_ack", {31'b0, wb_ack}, 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            mon_n = name_q.pop_front();
            $display("wb %s rdt=%08h exp=%08h", mon_n, wb_rdt, mon_e);
            chk(mon_n, wb_rdt, mon_e);
         end
         chk("ack_b2b", {31'b0, prev_ack}, 32'd0);
      end else if (prev_ack) begin
         chk("rdt_idle", wb_rdt, 32'd0);
      end
      prev_ack = wb_ack;
   end

   task automatic wb_xfer(input logic we, input logic [11:0] adr, input logic [31:0] dat,
                          input logic [31:0] exp, input string name);
      bit got = 0;
      exp_q.push_back(we ? 32'd0 : exp);
      name_q.push_back(we ? {name, "_wr"} : name);
      wb_cyc = 1'b1; wb_we = we; wb_adr = adr; wb_dat = dat;
      for (int i = 0; i < 8 && !got; i++) begin
         @(posedge clk); #1;
         if (wb_ack) got = 1;
      end
      wb_cyc = 1'b0; wb_we = 1'b0;
      if (!got) begin
         chk({name, "_ack_timeout"}, {31'b0, wb_ack}, 32'd1);
         void'(exp_q.pop_back());
         void'(name_q.pop_back());
      end
   endtask

   task automatic wb_read(input logic [11:0] adr, input logic [31:0] exp, input string name);
      wb_xfer(1'b0, adr, 32'd0, exp, name);
   endtask

   task automatic wr_target(input int t);
      wb_xfer(1'b1, 12'h004, 32'(t), 32'd0, "target");
      m_target = t;
   endtask

   task automatic rd_status(input string nm);
      wb_read(12'h008, {29'b0, m_sat, m_done, m_run}, nm);
      m_done = 0;
   endtask

   task automatic check_pins(input string nm);
      chk({nm, "_irq"}, {31'b0, irq}, {31'b0, m_done});
      chk({nm, "_busy"}, {31'b0, busy}, {31'b0, m_run});
   endtask

   task automatic ctrl_write(input logic [31:0] dat);
      int n = 0;
      wb_xfer(1'b1, 12'h000, dat, 32'd0, "ctrl");
      m_done = 0;
      if (m_run) begin
         if (dat[3]) m_run = 0;
      end else begin
         m_cont = dat[2];
         if (dat[1]) begin
            repeat (NBINS) begin
               if (busy) n++;
               @(posedge clk); #1;
            end
            chk("clear_busy_cycles", n, NBINS);
            chk("busy_after_clear", {31'b0, busy}, {31'b0, dat[0]});
            for (int c = 0; c < NCH; c++)
               for (int b = 0; b < NBINS; b++) m_bin[c][b] = 0;
            m_ev = 0; m_sat = 0; m_run = dat[0];
         end else if (dat[0]) begin
            m_run = 1; m_ev = 0; m_sat = 0;
         end
      end
   endtask

   // One event cycle; the model admits channels in index order up to target.
   task automatic ev_cycle(input logic [NCH-1:0] v, input int b0, input int b1);
      ev_valid = v;
      ev_bin = {6'(b1), 6'(b0)};
      @(posedge clk); #1;
      ev_valid = '0;
      if (m_run) begin
         for (int c = 0; c < NCH; c++) begin
            if (v[c] && (m_target == 0 || m_ev < m_target)) begin
               int bb = (c == 0) ? b0 : b1;
               if (m_bin[c][bb] < BMAX) m_bin[c][bb]++;
               if (m_bin[c][bb] == BMAX) m_sat = 1;
               m_ev = (m_ev + 1) % (1 << NMW);
            end
         end
         if (m_target != 0 && m_ev == m_target) begin
            m_done = 1;
            chk("irq_on_done", {31'b0, irq}, 32'd1);
            if (m_cont) begin
               @(posedge clk); #1;
               m_ev = 0;
            end else begin
               m_run = 0;
            end
         end
      end
   endtask

   task automatic sweep_bins(input string tag);
      for (int c = 0; c < NCH; c++)
         for (int b = 0; b < NBINS; b++)
            wb_read(bin_addr(c, b), 32'(m_bin[c][b]), $sformatf("%s_bin%0d_%0d", tag, c, b));
   endtask

   task automatic do_reset(input string nm);
      rst = 1'b1;
      @(posedge clk); #1;
      chk({nm, "_rst_busy"}, {31'b0, busy}, 32'd0);
      chk({nm, "_rst_irq"}, {31'b0, irq}, 32'd0);
      chk({nm, "_rst_ack"}, {31'b0, wb_ack}, 32'd0);
      rst = 1'b0;
      m_run = 0; m_done = 0; m_sat = 0; m_ev = 0; m_target = 0; m_cont = 0;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("reset_busy", {31'b0, busy}, 32'd0);
      chk("reset_irq", {31'b0, irq}, 32'd0);
      chk("reset_ack", {31'b0, wb_ack}, 32'd0);
      chk("reset_rdt", wb_rdt, 32'd0);
      rst = 1'b0;
      wb_read(12'h000, 32'd0, "ctrl_rst");
      wb_read(12'h004, 32'd0, "target_rst");
      wb_read(12'h008, 32'd0, "status_rst");
      wb_read(12'h00C, 32'd0, "evcnt_rst");
      wb_read(12'h010, 32'd0, "unmapped_010");
      wb_read(12'h7FC, 32'd0, "unmapped_7fc");

      // Clear, then every bin must read zero.
      ctrl_write(32'h2);
      sweep_bins("clr");

      // Ten back-to-back hits on one bin.
      wr_target(10);
      wb_read(12'h004, 32'd10, "target_rb");
      ctrl_write(32'h1);
      for (int i = 0; i < 10; i++) ev_cycle(2'b01, 5, 0);
      wb_read(bin_addr(0, 5), 32'(m_bin[0][5]), "bin0_5");
      wb_read(12'h00C, 32'(m_ev), "evcnt_10");
      check_pins("done10");
      ev_cycle(2'b11, 7, 7);   // dropped outside RUN
      rd_status("status_done10");
      check_pins("after_rd");
      wb_read(bin_addr(0, 7), 32'(m_bin[0][7]), "bin0_7_dropped");

      // Target reached mid-cycle: lower channel wins.
      wr_target(5);
      ctrl_write(32'h1);
      for (int i = 0; i < 4; i++) ev_cycle(2'b01, $urandom_range(0, NBINS - 1), 0);
      ev_cycle(2'b11, 1, 2);
      wb_read(bin_addr(0, 1), 32'(m_bin[0][1]), "bin0_1");
      wb_read(bin_addr(1, 2), 32'(m_bin[1][2]), "bin1_2");
      wb_read(12'h00C, 32'(m_ev), "evcnt_5");
      rd_status("status_done5");

      // Saturation with free-running target, CLEAR ignored while busy, ABORT.
      wr_target(0);
      ctrl_write(32'h1);
      for (int i = 0; i < 10; i++) ev_cycle(2'b10, 0, 63);
      ctrl_write(32'h2);
      check_pins("clear_ignored");
      for (int i = 0; i < 10; i++) ev_cycle(2'b10, 0, 63);
      wb_read(bin_addr(1, 63), 32'(m_bin[1][63]), "bin1_63_sat");
      rd_status("status_sat_run");
      wb_read(12'h00C, 32'(m_ev), "evcnt_20");
      ctrl_write(32'h8);
      check_pins("abort");
      rd_status("status_abort");

      // Continuous mode: two completions, irq held until STATUS read.
      wr_target(3);
      ctrl_write(32'h5);
      for (int i = 0; i < 7; i++) begin
         if ($urandom_range(0, 1) == 0) ev_cycle(2'b01, $urandom_range(0, NBINS - 1), 0);
         else ev_cycle(2'b10, 0, $urandom_range(0, NBINS - 1));
      end
      check_pins("cont7");
      wb_read(12'h00C, 32'(m_ev), "evcnt_cont");
      rd_status("status_cont");
      check_pins("cont_after_rd");
      ctrl_write(32'h8);

      // Randomized: CLEAR+START, random multi-channel traffic to few bins.
      wr_target($urandom_range(20, 40));
      ctrl_write(32'h3);
      for (int i = 0; i < 100 && m_run; i++)
         ev_cycle(2'($urandom_range(0, 3)), $urandom_range(0, 7), $urandom_range(0, 7));
      check_pins("rand");
      wb_read(12'h00C, 32'(m_ev), "evcnt_rand");
      rd_status("status_rand");
      sweep_bins("rand");

      // Reset mid-CLEAR, mid-RUN and with irq pending.
      wb_xfer(1'b1, 12'h000, 32'h2, 32'd0, "ctrl_clr_raw");
      repeat (10) @(posedge clk);
      #1;
      chk("busy_mid_clear", {31'b0, busy}, 32'd1);
      do_reset("mid_clear");
      rd_status("status_after_rst1");
      wb_read(12'h004, 32'd0, "target_after_rst1");
      wr_target(0);
      ctrl_write(32'h1);
      for (int i = 0; i < 5; i++) ev_cycle(2'b11, 3, 4);
      do_reset("mid_run");
      wb_read(12'h00C, 32'd0, "evcnt_after_rst2");
      rd_status("status_after_rst2");
      wr_target(2);
      ctrl_write(32'h1);
      ev_cycle(2'b11, 9, 9);
      check_pins("irq_before_rst");
      do_reset("irq_pending");
      rd_status("status_after_rst3");

      repeat (3) @(posedge clk);
      #1;
      chk("queue_drained", exp_q.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end
endmodule
